mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine_if.sv | 24 ++
 rtl/mem_copy_engine.sv | 109 ++++++++++
 tb/tb_mem_copy_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Data-memory bus between the copy engine (master) and the memory/arbiter side (slave).
interface mem_copy_engine_if;
    logic [31:0] MemAddr;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        BUS_GNT;

    modport master (
        output MemAddr,
        output MemWrite,
        output WriteData,
        input  ReadData,
        input  BUS_GNT
    );

    modport slave (
        input  MemAddr,
        input  MemWrite,
        input  WriteData,
        output ReadData,
        output BUS_GNT
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word copy engine: one bus read and one range-checked bus write per word.
// Define MEM_COPY_CHECKSUM_EN to build the running checksum of written words.
module mem_copy_engine #(
    parameter logic [31:0] DST_LO = 32'h0000_0800,
    parameter logic [31:0] DST_HI = 32'h0000_09FC
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       SRC_ADDR,
    input  logic [31:0]       DST_ADDR,
    input  logic [7:0]        LEN,
    mem_copy_engine_if.master bus,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [31:0]       CHECKSUM
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t      state;
    logic [31:0] src_ptr;
    logic [31:0] dst_ptr;
    logic [31:0] data_reg;
    logic [7:0]  remaining;
    logic        dst_ok;
    logic        wr_fire;

    function automatic logic in_dst_range(input logic [31:0] addr);
        return (addr >= DST_LO) && (addr <= DST_HI);
    endfunction

    assign dst_ok  = in_dst_range(dst_ptr);
    assign wr_fire = (state == WRITE) && bus.BUS_GNT && dst_ok;

    // Bus strobes are decoded from state so an asynchronous reset kills a write at once.
    assign bus.MemAddr   = (state == READ) ? src_ptr : dst_ptr;
    assign bus.MemWrite  = wr_fire;
    assign bus.WriteData = data_reg;
    assign BUSY          = (state == READ) || (state == WRITE);
    assign DONE          = (state == FIN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_reg  <= '0;
            remaining <= '0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        src_ptr   <= SRC_ADDR & ~32'h3;
                        dst_ptr   <= DST_ADDR & ~32'h3;
                        remaining <= LEN;
                        ERR       <= 1'b0;
                        state     <= (LEN != 8'd0) ? READ : FIN;
                    end
                end
                READ: begin
                    if (bus.BUS_GNT) begin
                        data_reg <= bus.ReadData;
                        src_ptr  <= src_ptr + 32'd4;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.BUS_GNT) begin
                        if (dst_ok) begin
                            dst_ptr   <= dst_ptr + 32'd4;
                            remaining <= remaining - 8'd1;
                            state     <= (remaining == 8'd1) ? FIN : READ;
                        end else begin
                            // Out-of-range destination: drop the write and end the copy.
                            ERR   <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            checksum_reg <= '0;
        end else if ((state == IDLE) && START) begin
            checksum_reg <= '0;
        end else if (wr_fire) begin
            checksum_reg <= checksum_reg + data_reg;
        end
    end

    assign CHECKSUM = checksum_reg;
`else
    assign CHECKSUM = '0;
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: word-level copy model with randomized copies and bus stalls.
module tb_mem_copy_engine;
    localparam logic [31:0] DST_LO = 32'h0000_0800;
    localparam logic [31:0] DST_HI = 32'h0000_09FC;
    localparam logic [31:0] SENT   = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        gnt = 1'b1;
    logic [31:0] SRC_ADDR = '0;
    logic [31:0] DST_ADDR = '0;
    logic [7:0]  LEN = '0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] CHECKSUM;

    logic [31:0] mem [0:1023];
    logic [31:0] mm  [0:1023];
    int checks = 0;
    int failures = 0;

    mem_copy_engine_if bus();
    assign bus.BUS_GNT  = gnt;
    assign bus.ReadData = (bus.MemAddr < 32'h1000) ? mem[bus.MemAddr[11:2]] : 32'h0;

    mem_copy_engine #(.DST_LO(DST_LO), .DST_HI(DST_HI)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
        .bus(bus),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] widx(input logic [31:0] a);
        return a[11:2];
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a < 32'h1000) ? mm[widx(a)] : 32'h0;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_memaddr"}, bus.MemAddr, 32'h0);
        check_eq({pfx, "_memwrite"}, 32'(bus.MemWrite), 32'h0);
        check_eq({pfx, "_wdata"}, bus.WriteData, 32'h0);
        check_eq({pfx, "_busy"}, 32'(BUSY), 32'h0);
        check_eq({pfx, "_done"}, 32'(DONE), 32'h0);
        check_eq({pfx, "_err"}, 32'(ERR), 32'h0);
        check_eq({pfx, "_cksum"}, CHECKSUM, 32'h0);
    endtask

    // mode: 0 grant always high, 1 random grant, 2 grant low for cycles 3..5 after the start edge
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [7:0] len,
                            input int mode, input bit poke);
        logic [31:0] s, d, w, sum, exp_ck, prev_addr, prev_wd, wa, wd;
        logic [31:0] adq[$];
        logic [31:0] daq[$];
        bit exp_err, prev_stall, pend;
        int steps, done_steps, cyc, mism;

        for (int i = 0; i < 1024; i++) mm[10'(i)] = mem[10'(i)];
        s = src & ~32'h3;
        d = dst & ~32'h3;
        exp_err = 1'b0;
        sum = '0;
        for (int i = 0; i < int'(len); i++) begin
            if (d < DST_LO || d > DST_HI) begin
                exp_err = 1'b1;
                break;
            end
            w = model_rd(s);
            adq.push_back(d);
            daq.push_back(w);
            sum += w;
            mm[widx(d)] = w;
            s += 32'd4;
            d += 32'd4;
        end
        steps = exp_err ? 2 * adq.size() + 2 : 2 * int'(len);
`ifdef MEM_COPY_CHECKSUM_EN
        exp_ck = sum;
`else
        exp_ck = 32'h0;
`endif

        START = 1'b1; SRC_ADDR = src; DST_ADDR = dst; LEN = len; gnt = 1'b1;
        @(negedge CLK);
        check_eq("idle_busy", 32'(BUSY), 32'h0);
        @(posedge CLK); #1;
        START = 1'b0; SRC_ADDR = $urandom; DST_ADDR = $urandom; LEN = 8'($urandom);
        done_steps = 0; cyc = 0; prev_stall = 1'b0; prev_addr = '0; prev_wd = '0;
        wa = '0; wd = '0;
        forever begin
            @(negedge CLK);
            pend = 1'b0;
            if (done_steps == steps) begin
                check_eq("done", 32'(DONE), 32'h1);
                check_eq("done_busy", 32'(BUSY), 32'h0);
                check_eq("done_err", 32'(ERR), 32'(exp_err));
                check_eq("done_memwrite", 32'(bus.MemWrite), 32'h0);
                check_eq("done_cksum", CHECKSUM, exp_ck);
                break;
            end
            check_eq("busy", 32'(BUSY), 32'h1);
            check_eq("busy_done", 32'(DONE), 32'h0);
            check_eq("busy_err", 32'(ERR), 32'h0);
            if (prev_stall) begin
                check_eq("stall_addr_hold", bus.MemAddr, prev_addr);
                check_eq("stall_wdata_hold", bus.WriteData, prev_wd);
            end
            if (!gnt) check_eq("stall_memwrite", 32'(bus.MemWrite), 32'h0);
            if (mode == 2 && !gnt) check_eq("stall_addr_814", bus.MemAddr, 32'h814);
            if (bus.MemWrite) begin
                if (adq.size() == 0) begin
                    check_eq("wr_unexpected", 32'(bus.MemWrite), 32'h0);
                end else begin
                    check_eq("wr_addr", bus.MemAddr, adq.pop_front());
                    check_eq("wr_data", bus.WriteData, daq.pop_front());
                end
                pend = 1'b1; wa = bus.MemAddr; wd = bus.WriteData;
            end
            prev_stall = !gnt; prev_addr = bus.MemAddr; prev_wd = bus.WriteData;
            if (gnt) done_steps++;
            cyc++;
            if (cyc > 3000) begin
                check_eq("timeout", 32'(cyc), 32'h0);
                break;
            end
            @(posedge CLK);
            if (pend && wa < 32'h1000) mem[widx(wa)] = wd;
            #1;
            case (mode)
                1:       gnt = ($urandom_range(0, 3) != 0);
                2:       gnt = !(cyc >= 3 && cyc <= 5);
                default: gnt = 1'b1;
            endcase
            START = poke ? 1'($urandom) : 1'b0;
        end
        START = 1'b0; gnt = 1'b1;
        check_eq("writes_left", 32'(adq.size()), 32'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check_eq("after_done", 32'(DONE), 32'h0);
        check_eq("err_hold", 32'(ERR), 32'(exp_err));
        check_eq("cksum_hold", CHECKSUM, exp_ck);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[10'(i)] !== mm[10'(i)]) mism++;
        check_eq("mem_image", 32'(mism), 32'h0);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] wa, wd;
        bit pend;
        logic [31:0] rs, rdst;
        logic [7:0]  rl;

        for (int i = 0; i < 1024; i++) mem[10'(i)] = 32'h0;
        for (int i = 128; i < 256; i++) mem[10'(i)] = $urandom;
        for (int i = 512; i < 640; i++) mem[10'(i)] = SENT | 32'(i);
        mem[widx(32'h20C)] = 32'd5;
        mem[widx(32'h210)] = 32'd6;
        mem[widx(32'h214)] = 32'd3;

        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RESET = 1'b0;

        run_copy(32'h20C, 32'h810, 8'd3, 0, 1'b0);
        check_eq("basic_810", mem[widx(32'h810)], 32'd5);
        check_eq("basic_814", mem[widx(32'h814)], 32'd6);
        check_eq("basic_818", mem[widx(32'h818)], 32'd3);
`ifdef MEM_COPY_CHECKSUM_EN
        check_eq("basic_cksum", CHECKSUM, 32'hE);
`endif

        run_copy(32'h200, 32'h800, 8'd0, 0, 1'b0);
        run_copy(32'h20C, 32'h810, 8'd3, 2, 1'b0);
        run_copy(32'h20C, 32'h9F8, 8'd3, 0, 1'b0);
        check_eq("edge_9fc", mem[widx(32'h9FC)], 32'd6);

        // Reset during the second write: only the first word may land.
        for (int i = 0; i < 3; i++) mem[widx(32'h810 + 32'(4 * i))] = SENT;
        START = 1'b1; SRC_ADDR = 32'h20C; DST_ADDR = 32'h810; LEN = 8'd3; gnt = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_w0_strobe", 32'(bus.MemWrite), 32'h1);
        check_eq("rst_w0_addr", bus.MemAddr, 32'h810);
        pend = bus.MemWrite; wa = bus.MemAddr; wd = bus.WriteData;
        @(posedge CLK);
        if (pend && wa < 32'h1000) mem[widx(wa)] = wd;
        @(posedge CLK); #1;
        check_eq("rst_pre_wr", 32'(bus.MemWrite), 32'h1);
        RESET = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge CLK);
        check_eq("rst_hold_memwrite", 32'(bus.MemWrite), 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        check_eq("rst_mem_810", mem[widx(32'h810)], 32'd5);
        check_eq("rst_mem_814", mem[widx(32'h814)], SENT);
        check_eq("rst_mem_818", mem[widx(32'h818)], SENT);

        run_copy(32'h20C, 32'h810, 8'd3, 0, 1'b1);
        run_copy(32'hFFFF_FFF8, 32'h900, 8'd4, 1, 1'b0);
        run_copy(32'h20F, 32'h7FC, 8'd2, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            rs = 32'h200 + 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
            if (t % 5 == 4) rs = $urandom;
            rdst = 32'h7F0 + 32'($urandom_range(0, 140)) * 32'd4;
            rl = 8'($urandom_range(0, 24));
            run_copy(rs, rdst, rl, 1, (t % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
